// File: rtl/pll_rst_pkg.sv
// Shared types and helpers for the PLL reset / clock-enable generator.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_STABLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam logic [1:0] SPEED_X1 = 2'd0;
    localparam logic [1:0] SPEED_X2 = 2'd1;
    localparam logic [1:0] SPEED_X4 = 2'd2;
    localparam logic [1:0] SPEED_X8 = 2'd3;

    function automatic int unsigned cpu_div_sel(input logic [1:0] speed_sel,
                                                input int unsigned cpu_div);
        case (speed_sel)
            SPEED_X2: cpu_div_sel = cpu_div >> 1;
            SPEED_X4: cpu_div_sel = cpu_div >> 2;
            SPEED_X8: cpu_div_sel = cpu_div >> 3;
            default:  cpu_div_sel = cpu_div;
        endcase
    endfunction

endpackage

// File: rtl/ce_divider.sv
// Free-running divider producing a registered one-cycle enable on each wrap.
// With latch_at_wrap_i set, a new divisor only takes effect at the next period.
module ce_divider #(
    parameter  int MAX_DIV = 4,
    localparam int CNT_W   = $clog2(MAX_DIV),
    localparam int DIV_W   = $clog2(MAX_DIV + 1)
) (
    input  logic             clk_sys,
    input  logic             clear_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             latch_at_wrap_i,
    output logic             ce_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             ce_q, ce_d;
    logic [DIV_W-1:0] div_eff;
    logic             wrap;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        div_eff = latch_at_wrap_i ? div_q : div_i;
        wrap    = (DIV_W'(cnt_q) >= div_eff - DIV_W'(1));
        cnt_d   = cnt_q;
        div_d   = div_q;
        ce_d    = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
            div_d = div_i;
        end else if (wrap) begin
            cnt_d = '0;
            div_d = div_i;
            ce_d  = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: no reset branch here; the parent folds its synchronous reset into clear_i.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_sys) begin
        cnt_q <= cnt_d;
        div_q <= div_d;
        ce_q  <= ce_d;
    end

    assign ce_o = ce_q;

endmodule

// File: rtl/pll_reset_ce_gen.sv
// Holds the core in reset until the PLL has been locked for a stable window, then issues pixel/CPU enables.
// Optional lock-loss event counter enabled by defining PLL_LOCK_LOSS_CNT_EN.
module pll_reset_ce_gen
    import pll_rst_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int PIX_DIV            = 4,
    parameter int CPU_DIV            = 24
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic [1:0] speed_sel,
    output logic       sys_reset,
    output logic       ce_pix,
    output logic       ce_cpu
`ifdef PLL_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    localparam int SC_W   = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int PIX_DW = $clog2(PIX_DIV + 1);
    localparam int CPU_DW = $clog2(CPU_DIV + 1);
    localparam logic [SC_W-1:0]   SC_LAST   = SC_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [PIX_DW-1:0] PIX_DIV_V = PIX_DW'(PIX_DIV);

    logic            sync1_q, locked_s_q;
    state_t          state_q, state_d;
    logic [SC_W-1:0] stable_cnt_q, stable_cnt_d;
    logic            sys_reset_q;
    logic            ce_clear;
    logic [CPU_DW-1:0] cpu_div;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= pll_locked;
            locked_s_q <= sync1_q;
        end
    end

    // Any drop of the synchronised lock abandons the window; there is no partial credit.
    always_comb begin
        state_d      = state_q;
        stable_cnt_d = '0;
        case (state_q)
            ST_WAIT: begin
                if (locked_s_q) state_d = ST_STABLE;
            end
            ST_STABLE: begin
                if (!locked_s_q)                 state_d = ST_WAIT;
                else if (stable_cnt_q == SC_LAST) state_d = ST_RUN;
                else                             stable_cnt_d = stable_cnt_q + SC_W'(1);
            end
            ST_RUN: begin
                if (!locked_s_q) state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= ST_WAIT;
            stable_cnt_q <= '0;
            sys_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            stable_cnt_q <= stable_cnt_d;
            sys_reset_q  <= (state_d != ST_RUN);
        end
    end

    assign sys_reset = sys_reset_q;

    // Enables only run while RUN both now and next, so they stop on the very edge RUN is left.
    assign ce_clear = reset || (state_q != ST_RUN) || (state_d != ST_RUN);
    assign cpu_div  = CPU_DW'(cpu_div_sel(speed_sel, CPU_DIV));

    ce_divider #(.MAX_DIV(PIX_DIV)) u_ce_pix (
        .clk_sys        (clk_sys),
        .clear_i        (ce_clear),
        .div_i          (PIX_DIV_V),
        .latch_at_wrap_i(1'b0),
        .ce_o           (ce_pix)
    );

    ce_divider #(.MAX_DIV(CPU_DIV)) u_ce_cpu (
        .clk_sys        (clk_sys),
        .clear_i        (ce_clear),
        .div_i          (cpu_div),
        .latch_at_wrap_i(1'b1),
        .ce_o           (ce_cpu)
    );

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            lock_loss_cnt_q <= 8'd0;
        end else if ((state_q == ST_RUN) && !locked_s_q && (lock_loss_cnt_q != 8'hFF)) begin
            lock_loss_cnt_q <= lock_loss_cnt_q + 8'd1;
        end
    end

    assign lock_loss_cnt = lock_loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_reset_ce_gen.sv
// Directed scoreboard bench for pll_reset_ce_gen (LOCK_STABLE_CYCLES=8, PIX_DIV=4, CPU_DIV=24).
// Lock-loss counter checks are included when PLL_LOCK_LOSS_CNT_EN is defined.
module tb_pll_reset_ce_gen;

    localparam int N_STABLE = 8;
    localparam int SEL_RELEASE = 0;
    localparam int SEL_RESET   = 1;
    localparam int SEL_PIX     = 2;
    localparam int SEL_CPU     = 3;

    logic       clk_sys;
    logic       reset;
    logic       pll_locked;
    logic [1:0] speed_sel;
    logic       sys_reset;
    logic       ce_pix;
    logic       ce_cpu;
`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    pll_reset_ce_gen #(
        .LOCK_STABLE_CYCLES(N_STABLE),
        .PIX_DIV           (4),
        .CPU_DIV           (24)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .pll_locked(pll_locked),
        .speed_sel (speed_sel),
        .sys_reset (sys_reset),
        .ce_pix    (ce_pix),
        .ce_cpu    (ce_cpu)
`ifdef PLL_LOCK_LOSS_CNT_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [31:0] exp);
        sb.push_back('{tag, exp});
    endtask

    task automatic check_obs(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: observed=%0d expected=none", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.exp);
        end
    endtask

    function automatic logic sig_of(input int sel);
        case (sel)
            SEL_RELEASE: sig_of = (sys_reset === 1'b0);
            SEL_RESET:   sig_of = (sys_reset === 1'b1);
            SEL_PIX:     sig_of = (ce_pix === 1'b1);
            default:     sig_of = (ce_cpu === 1'b1);
        endcase
    endfunction

    // Counts edges (inclusive) until the selected event is seen; -1 if the bound expires.
    task automatic wait_for(input int sel, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sig_of(sel) && n < limit);
        if (!sig_of(sel)) n = -1;
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        pll_locked = 1'b0;
        speed_sel  = 2'd0;
        repeat (3) tick();

        push_exp("rst_sys_reset", 1);  check_obs(32'(sys_reset));
        push_exp("rst_ce_pix", 0);     check_obs(32'(ce_pix));
        push_exp("rst_ce_cpu", 0);     check_obs(32'(ce_cpu));
`ifdef PLL_LOCK_LOSS_CNT_EN
        push_exp("rst_lock_loss_cnt", 0); check_obs(32'(lock_loss_cnt));
`endif

        // Power-up: release reset, then lock.
        reset = 1'b0;
        repeat (4) tick();
        push_exp("wait_holds_reset", 1); check_obs(32'(sys_reset));
        pll_locked = 1'b1;
        push_exp("release_latency", N_STABLE + 3);
        wait_for(SEL_RELEASE, 50, n); check_obs(n);
        push_exp("first_ce_pix", 4);
        wait_for(SEL_PIX, 20, n); check_obs(n);
        push_exp("pix_period", 4);
        wait_for(SEL_PIX, 20, n); check_obs(n);
        push_exp("first_ce_cpu_rest", 16);
        wait_for(SEL_CPU, 40, n); check_obs(n);
        push_exp("pix_cpu_coincide", 1); check_obs(32'(ce_pix));

        // Speed change mid-period: current period unaffected, new rate next period.
        repeat (10) tick();
        speed_sel = 2'd3;
        push_exp("cpu_period_kept", 14);
        wait_for(SEL_CPU, 40, n); check_obs(n);
        push_exp("cpu_fast_period1", 3);
        wait_for(SEL_CPU, 40, n); check_obs(n);
        push_exp("cpu_fast_period2", 3);
        wait_for(SEL_CPU, 40, n); check_obs(n);
        speed_sel = 2'd0;
        push_exp("cpu_fast_tail", 3);
        wait_for(SEL_CPU, 40, n); check_obs(n);
        push_exp("cpu_slow_again", 24);
        wait_for(SEL_CPU, 40, n); check_obs(n);

        // Lock loss in RUN, timed so the drop lands on a pixel wrap edge.
        pll_locked = 1'b0;
        push_exp("lock_loss_latency", 3);
        wait_for(SEL_RESET, 20, n); check_obs(n);
        push_exp("loss_ce_pix_off", 0); check_obs(32'(ce_pix));
        push_exp("loss_ce_cpu_off", 0); check_obs(32'(ce_cpu));
`ifdef PLL_LOCK_LOSS_CNT_EN
        push_exp("lock_loss_cnt_one", 1); check_obs(32'(lock_loss_cnt));
`endif
        pll_locked = 1'b1;
        push_exp("relock_latency", N_STABLE + 3);
        wait_for(SEL_RELEASE, 50, n); check_obs(n);
        push_exp("relock_first_cpu", 24);
        wait_for(SEL_CPU, 40, n); check_obs(n);

        // reset asserted on the edge where ce_cpu would wrap.
        repeat (23) tick();
        reset = 1'b1;
        tick();
        push_exp("rst_run_sys_reset", 1); check_obs(32'(sys_reset));
        push_exp("rst_run_ce_cpu", 0);    check_obs(32'(ce_cpu));
        push_exp("rst_run_ce_pix", 0);    check_obs(32'(ce_pix));
`ifdef PLL_LOCK_LOSS_CNT_EN
        push_exp("rst_run_lock_loss", 0); check_obs(32'(lock_loss_cnt));
`endif

        // Glitch during STABLE restarts the whole window.
        pll_locked = 1'b0;
        reset      = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        repeat (8) tick();
        push_exp("stable_holds_reset", 1); check_obs(32'(sys_reset));
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        push_exp("glitch_release_latency", N_STABLE + 3);
        wait_for(SEL_RELEASE, 50, n); check_obs(n);
        push_exp("glitch_first_ce_pix", 4);
        wait_for(SEL_PIX, 20, n); check_obs(n);

        // Repeated lock-loss events; counter saturates when present.
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            push_exp("sat_loss_latency", 3);
            wait_for(SEL_RESET, 20, n); check_obs(n);
            pll_locked = 1'b1;
            push_exp("sat_release_latency", N_STABLE + 3);
            wait_for(SEL_RELEASE, 50, n); check_obs(n);
`ifdef PLL_LOCK_LOSS_CNT_EN
            if (i == 0) begin
                push_exp("lock_loss_cnt_first", 1); check_obs(32'(lock_loss_cnt));
            end
            if (i == 254) begin
                push_exp("lock_loss_cnt_255", 255); check_obs(32'(lock_loss_cnt));
            end
`endif
        end
`ifdef PLL_LOCK_LOSS_CNT_EN
        push_exp("lock_loss_cnt_sat", 255); check_obs(32'(lock_loss_cnt));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
